trig_buffer_alloc: RTL and testbench

//  Parametrised successor to the simple buffer counter: tracks WHICH of NBUF SURF event

---
 rtl/trig_buffer_alloc_if.sv | 44 ++++
 rtl/trig_buffer_alloc.sv | 137 +++++++++++++
 tb/tb_trig_buffer_alloc.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/trig_buffer_alloc_if.sv
// Trigger/readout bus for trig_buffer_alloc; dead_count_o exists only with
// TRIG_BUFFER_ALLOC_DEADTIME_EN defined.
interface trig_buffer_alloc_if #(
    parameter int unsigned NBUF      = 4,
    parameter int unsigned OCC_WIDTH = 32
);
    localparam int unsigned NBUF_BITS = $clog2(NBUF);

    logic                 pps_i;
    logic                 runrst_i;
    logic                 runstop_i;
    logic                 trig_i;
    logic [NBUF_BITS-1:0] trig_buf_o;
    logic                 trig_ack_o;
    logic                 last_flag_i;
    logic [NBUF_BITS-1:0] last_buf_i;
    logic [NBUF-1:0]      held_o;
    logic [NBUF_BITS:0]   count_o;
    logic                 dead_o;
    logic [OCC_WIDTH-1:0] occupancy_o;
    logic                 surf_err_o;
    logic                 turf_err_o;
`ifdef TRIG_BUFFER_ALLOC_DEADTIME_EN
    logic [OCC_WIDTH-1:0] dead_count_o;
`endif

    modport master (
        output pps_i, runrst_i, runstop_i, trig_i, last_flag_i, last_buf_i,
        input  trig_buf_o, trig_ack_o, held_o, count_o, dead_o, occupancy_o,
`ifdef TRIG_BUFFER_ALLOC_DEADTIME_EN
        input  dead_count_o,
`endif
        input  surf_err_o, turf_err_o
    );

    modport slave (
        input  pps_i, runrst_i, runstop_i, trig_i, last_flag_i, last_buf_i,
        output trig_buf_o, trig_ack_o, held_o, count_o, dead_o, occupancy_o,
`ifdef TRIG_BUFFER_ALLOC_DEADTIME_EN
        output dead_count_o,
`endif
        output surf_err_o, turf_err_o
    );
endinterface

// File: rtl/trig_buffer_alloc.sv
// Round-robin SURF event buffer allocator with deadtime, error flags and per-second occupancy.
// Optional deadtime counter enabled by defining TRIG_BUFFER_ALLOC_DEADTIME_EN.
module trig_buffer_alloc #(
    parameter int unsigned NBUF      = 4,
    parameter int unsigned OCC_WIDTH = 32
) (
    input logic             sys_clk_i,
    input logic             sys_rst_i,
    trig_buffer_alloc_if.slave bus
);
    localparam int unsigned NBUF_BITS = $clog2(NBUF);

    logic [NBUF-1:0]      held, held_n;
    logic [NBUF_BITS-1:0] ptr, ptr_n, ptr_inc;
    logic [NBUF_BITS-1:0] trig_buf, buf_n;
    logic [NBUF_BITS:0]   count, count_n;
    logic                 running, run_n;
    logic                 surf_err, surf_n;
    logic                 turf_err, turf_n;
    logic                 ack, ack_n;
    logic                 dead, dead_n;
    logic                 last_held;
    logic [OCC_WIDTH-1:0] acc, occupancy, acc_sat;
    logic [OCC_WIDTH:0]   acc_sum;

    assign ptr_inc   = (ptr == NBUF_BITS'(NBUF - 1)) ? '0 : ptr + NBUF_BITS'(1);
    // Out-of-range indices (non-power-of-two NBUF) count as "not held"
    assign last_held = ({1'b0, bus.last_buf_i} < (NBUF_BITS + 1)'(NBUF)) && held[bus.last_buf_i];

    // Next-state: all decisions look at the registered pre-cycle held/ptr/running
    always_comb begin
        held_n = held;
        ptr_n  = ptr;
        run_n  = running;
        surf_n = surf_err;
        turf_n = turf_err;
        ack_n  = 1'b0;
        buf_n  = trig_buf;
        if (bus.runrst_i) begin
            held_n = '0;
            ptr_n  = '0;
            run_n  = 1'b1;
            surf_n = 1'b0;
            turf_n = 1'b0;
        end else begin
            if (bus.runstop_i) run_n = 1'b0;
            if (bus.trig_i) begin
                if (!held[ptr]) begin
                    held_n[ptr] = 1'b1;
                    ack_n       = 1'b1;
                    buf_n       = ptr;
                    ptr_n       = ptr_inc;
                end else if (running) begin
                    turf_n = 1'b1;
                end
            end
            if (bus.last_flag_i) begin
                if (last_held) held_n[bus.last_buf_i] = 1'b0;
                else if (running) surf_n = 1'b1;
            end
        end
        count_n = '0;
        for (int unsigned i = 0; i < NBUF; i++) count_n = count_n + (NBUF_BITS + 1)'(held_n[i]);
        dead_n = run_n & held_n[ptr_n];
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            held     <= '0;
            ptr      <= '0;
            trig_buf <= '0;
            count    <= '0;
            running  <= 1'b0;
            surf_err <= 1'b0;
            turf_err <= 1'b0;
            ack      <= 1'b0;
            dead     <= 1'b0;
        end else begin
            held     <= held_n;
            ptr      <= ptr_n;
            trig_buf <= buf_n;
            count    <= count_n;
            running  <= run_n;
            surf_err <= surf_n;
            turf_err <= turf_n;
            ack      <= ack_n;
            dead     <= dead_n;
        end
    end

    // Saturating occupancy accumulator, dumped on PPS including the PPS cycle itself
    assign acc_sum = {1'b0, acc} + (OCC_WIDTH + 1)'(count);
    assign acc_sat = acc_sum[OCC_WIDTH] ? '1 : acc_sum[OCC_WIDTH-1:0];

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            acc       <= '0;
            occupancy <= '0;
        end else if (bus.pps_i) begin
            acc       <= '0;
            occupancy <= acc_sat;
        end else begin
            acc       <= acc_sat;
        end
    end

`ifdef TRIG_BUFFER_ALLOC_DEADTIME_EN
    logic [OCC_WIDTH-1:0] dead_acc, dead_count, dead_sat;
    logic [OCC_WIDTH:0]   dead_sum;

    assign dead_sum = {1'b0, dead_acc} + (OCC_WIDTH + 1)'(dead);
    assign dead_sat = dead_sum[OCC_WIDTH] ? '1 : dead_sum[OCC_WIDTH-1:0];

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            dead_acc   <= '0;
            dead_count <= '0;
        end else if (bus.pps_i) begin
            dead_acc   <= '0;
            dead_count <= dead_sat;
        end else begin
            dead_acc   <= dead_sat;
        end
    end

    assign bus.dead_count_o = dead_count;
`endif

    assign bus.held_o      = held;
    assign bus.count_o     = count;
    assign bus.trig_buf_o  = trig_buf;
    assign bus.trig_ack_o  = ack;
    assign bus.dead_o      = dead;
    assign bus.surf_err_o  = surf_err;
    assign bus.turf_err_o  = turf_err;
    assign bus.occupancy_o = occupancy;
endmodule

// File: tb/tb_trig_buffer_alloc.sv
// Randomised + directed bench for trig_buffer_alloc against a behavioural model;
// a second instance with OCC_WIDTH=8 exercises occupancy saturation.
module tb_trig_buffer_alloc;
    localparam int NB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pps = 1'b0, runrst = 1'b0, runstop = 1'b0, trig = 1'b0, last_flag = 1'b0;
    logic [1:0] last_buf = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    trig_buffer_alloc_if #(.NBUF(NB), .OCC_WIDTH(32)) bus_a ();
    trig_buffer_alloc_if #(.NBUF(NB), .OCC_WIDTH(8))  bus_b ();

    assign bus_a.pps_i = pps;       assign bus_b.pps_i = pps;
    assign bus_a.runrst_i = runrst; assign bus_b.runrst_i = runrst;
    assign bus_a.runstop_i = runstop; assign bus_b.runstop_i = runstop;
    assign bus_a.trig_i = trig;     assign bus_b.trig_i = trig;
    assign bus_a.last_flag_i = last_flag; assign bus_b.last_flag_i = last_flag;
    assign bus_a.last_buf_i = last_buf;   assign bus_b.last_buf_i = last_buf;

    trig_buffer_alloc #(.NBUF(NB), .OCC_WIDTH(32)) dut_a (.sys_clk_i(clk), .sys_rst_i(rst), .bus(bus_a));
    trig_buffer_alloc #(.NBUF(NB), .OCC_WIDTH(8))  dut_b (.sys_clk_i(clk), .sys_rst_i(rst), .bus(bus_b));

    // Behavioural reference state
    int     m_held[NB];
    int     m_ptr, m_buf, m_cnt;
    bit     m_run, m_surf, m_turf, m_ack, m_dead;
    longint m_acc32, m_occ32, m_acc8, m_occ8, m_dacc, m_dcnt;

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [NB-1:0] held_mask();
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) m[i] = (m_held[i] != 0);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) m_held[i] = 0;
        m_ptr = 0; m_buf = 0; m_cnt = 0;
        m_run = 0; m_surf = 0; m_turf = 0; m_ack = 0; m_dead = 0;
        m_acc32 = 0; m_occ32 = 0; m_acc8 = 0; m_occ8 = 0; m_dacc = 0; m_dcnt = 0;
    endtask

    task automatic model_step(input bit t, input bit lf, input int lb, input bit p,
                              input bit rr, input bit rs);
        int pre[NB];
        bit was_run;
        if (p) begin
            m_occ32 = sat(m_acc32 + m_cnt, 32); m_acc32 = 0;
            m_occ8  = sat(m_acc8 + m_cnt, 8);   m_acc8  = 0;
            m_dcnt  = sat(m_dacc + m_dead, 32); m_dacc  = 0;
        end else begin
            m_acc32 = sat(m_acc32 + m_cnt, 32);
            m_acc8  = sat(m_acc8 + m_cnt, 8);
            m_dacc  = sat(m_dacc + m_dead, 32);
        end
        pre = m_held;
        was_run = m_run;
        m_ack = 0;
        if (rr) begin
            for (int i = 0; i < NB; i++) m_held[i] = 0;
            m_ptr = 0; m_run = 1; m_surf = 0; m_turf = 0;
        end else begin
            if (rs) m_run = 0;
            if (t) begin
                if (pre[m_ptr] == 0) begin
                    m_held[m_ptr] = 1; m_ack = 1; m_buf = m_ptr;
                    m_ptr = (m_ptr + 1) % NB;
                end else if (was_run) m_turf = 1;
            end
            if (lf) begin
                if (lb < NB && pre[lb] != 0) m_held[lb] = 0;
                else if (was_run) m_surf = 1;
            end
        end
        m_cnt = 0;
        for (int i = 0; i < NB; i++) m_cnt += m_held[i];
        m_dead = m_run && (m_held[m_ptr] != 0);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("held",   64'(bus_a.held_o), 64'(held_mask()));
        check("count",  64'(bus_a.count_o), 64'(m_cnt));
        check("ack",    64'(bus_a.trig_ack_o), 64'(m_ack));
        check("buf",    64'(bus_a.trig_buf_o), 64'(m_buf));
        check("dead",   64'(bus_a.dead_o), 64'(m_dead));
        check("surf",   64'(bus_a.surf_err_o), 64'(m_surf));
        check("turf",   64'(bus_a.turf_err_o), 64'(m_turf));
        check("occ32",  64'(bus_a.occupancy_o), 64'(m_occ32));
        check("occ8",   64'(bus_b.occupancy_o), 64'(m_occ8));
        check("held_b", 64'(bus_b.held_o), 64'(held_mask()));
`ifdef TRIG_BUFFER_ALLOC_DEADTIME_EN
        check("deadcnt", 64'(bus_a.dead_count_o), 64'(m_dcnt));
`endif
    endtask

    // One clock: drive after the falling edge, update model at the rising edge, check at the next fall
    task automatic cycle(input bit t, input bit lf, input int lb, input bit p,
                         input bit rr, input bit rs);
        trig = t; last_flag = lf; last_buf = 2'(lb); pps = p; runrst = rr; runstop = rs;
        @(posedge clk);
        model_step(t, lf, lb, p, rr, rs);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all();

        // Fill all four buffers in order
        cycle(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < NB; k++) begin
            cycle(1, 0, 0, 0, 0, 0);
            check("fill_ack", 64'(bus_a.trig_ack_o), 64'd1);
            check("fill_buf", 64'(bus_a.trig_buf_o), 64'(k));
            idle(2);
        end
        check("full_held", 64'(bus_a.held_o), 64'hF);
        check("full_cnt", 64'(bus_a.count_o), 64'd4);
        check("full_dead", 64'(bus_a.dead_o), 64'd1);

        // Trigger while full, then free buffer 0
        cycle(1, 0, 0, 0, 0, 0);
        check("drop_ack", 64'(bus_a.trig_ack_o), 64'd0);
        check("drop_turf", 64'(bus_a.turf_err_o), 64'd1);
        cycle(0, 1, 0, 0, 0, 0);
        check("free0_dead", 64'(bus_a.dead_o), 64'd0);
        cycle(1, 0, 0, 0, 0, 0);
        check("refill_buf", 64'(bus_a.trig_buf_o), 64'd0);

        // Out-of-order frees
        cycle(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        check("ooo_held", 64'(bus_a.held_o), 64'h4);
        cycle(1, 0, 0, 0, 0, 0);
        check("ooo_buf", 64'(bus_a.trig_buf_o), 64'd3);

        // SURF error: sticky, cleared by runrst, suppressed when stopped
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 1, 2, 0, 0, 0);
        check("surf_set", 64'(bus_a.surf_err_o), 64'd1);
        check("surf_held", 64'(bus_a.held_o), 64'h0);
        cycle(0, 0, 0, 0, 1, 0);
        check("surf_clr", 64'(bus_a.surf_err_o), 64'd0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 2, 0, 0, 0);
        check("surf_stop", 64'(bus_a.surf_err_o), 64'd0);

        // Occupancy: two buffers for a 100-cycle second, then four (saturates the 8-bit copy)
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        idle(99);
        cycle(0, 0, 0, 1, 0, 0);
        check("occ_200", 64'(bus_a.occupancy_o), 64'd200);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        idle(99);
        cycle(0, 0, 0, 1, 0, 0);
        check("occ_400", 64'(bus_a.occupancy_o), 64'd400);
        check("occ_sat8", 64'(bus_b.occupancy_o), 64'd255);

        // Same-cycle trigger and free of the allocation target
        cycle(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < NB; k++) cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check("same_ack", 64'(bus_a.trig_ack_o), 64'd0);
        check("same_turf", 64'(bus_a.turf_err_o), 64'd1);
        check("same_held", 64'(bus_a.held_o), 64'hE);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        check("arst_held", 64'(bus_a.held_o), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Random traffic
        cycle(0, 0, 0, 0, 1, 0);
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(99) < 50), ($urandom_range(99) < 40), int'($urandom_range(NB - 1)),
                  ($urandom_range(99) < 3), ($urandom_range(99) < 2), ($urandom_range(99) < 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
